// File: rtl/sram_port_arb.sv
// Round-robin arbiter merging N masters onto one SRAM native port.
// Ports: boot/m_* from masters, s_* to SRAM, grant/busy status.
module sram_port_arb #(
   parameter int N_MASTERS   = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int BOOT_MASTER = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         boot,
   input  logic [N_MASTERS-1:0]         m_valid,
   input  logic [N_MASTERS*ADDR_W-1:0]  m_addr,
   input  logic [N_MASTERS*DATA_W-1:0]  m_wdata,
   input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
   output logic [DATA_W-1:0]            m_rdata,
   output logic [N_MASTERS-1:0]         m_ready,
   output logic                         s_valid,
   output logic [ADDR_W-1:0]            s_addr,
   output logic [DATA_W-1:0]            s_wdata,
   output logic [DATA_W/8-1:0]          s_wstrb,
   input  logic [DATA_W-1:0]            s_rdata,
   input  logic                         s_ready,
   output logic [N_MASTERS-1:0]         grant,
   output logic                         busy
);

   localparam int IW = $clog2(N_MASTERS);
   localparam int SW = DATA_W / 8;

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t          state_q;
   logic [IW-1:0]   grant_q;
   logic [IW-1:0]   last_q;
   logic            busy_q;
   logic [IW-1:0]   pick_idx;
   logic [IW-1:0]   sel;
   logic            found;
   logic            any_req;
   logic            in_busy;

   assign any_req = |m_valid;
   assign in_busy = (state_q == BUSY);

   // Boot master first while booting, else rotate from last served.
   always_comb begin
      pick_idx = '0;
      found    = 1'b0;
      if (boot && m_valid[BOOT_MASTER]) begin
         pick_idx = IW'(BOOT_MASTER);
      end else begin
         for (int k = 1; k <= N_MASTERS; k++) begin
            if (!found &&
                m_valid[(int'(last_q) + k) % N_MASTERS]) begin
               pick_idx = IW'((int'(last_q) + k) % N_MASTERS);
               found    = 1'b1;
            end
         end
      end
   end

   assign sel = in_busy ? grant_q : pick_idx;

   assign s_valid = rst & m_valid[sel];
   assign s_addr  = m_addr[int'(sel)*ADDR_W +: ADDR_W];
   assign s_wdata = m_wdata[int'(sel)*DATA_W +: DATA_W];
   assign s_wstrb = m_wstrb[int'(sel)*SW +: SW];
   assign m_rdata = s_rdata;
   assign busy    = busy_q;

   // Outputs are forced low while reset is held, not just after an edge.
   always_comb begin
      grant   = '0;
      m_ready = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         grant[i]   = rst & (in_busy | any_req) &
                      (sel == IW'(i));
         m_ready[i] = rst & s_ready & in_busy &
                      (grant_q == IW'(i));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IW'(N_MASTERS - 1);
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (any_req) begin
                  grant_q <= pick_idx;
                  state_q <= BUSY;
                  busy_q  <= 1'b1;
               end
            end
            BUSY: begin
               if (s_ready) begin
                  last_q  <= grant_q;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_port_arb.sv
// Directed bench for sram_port_arb with N=2 and a small SRAM model.
// Inputs change on negedge; outputs checked 1ns later.
module tb_sram_port_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        boot;
   logic [1:0]  m_valid;
   logic [31:0] a0, a1, d0, d1;
   logic [3:0]  w0, w1;
   logic [31:0] m_rdata;
   logic [1:0]  m_ready;
   logic        s_valid;
   logic [31:0] s_addr;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic [31:0] s_rdata;
   logic        s_ready;
   logic [1:0]  grant;
   logic        busy;

   logic [31:0] mem [0:31];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sram_port_arb #(
      .N_MASTERS  (2),
      .ADDR_W     (32),
      .DATA_W     (32),
      .BOOT_MASTER(1)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .boot   (boot),
      .m_valid(m_valid),
      .m_addr ({a1, a0}),
      .m_wdata({d1, d0}),
      .m_wstrb({w1, w0}),
      .m_rdata(m_rdata),
      .m_ready(m_ready),
      .s_valid(s_valid),
      .s_addr (s_addr),
      .s_wdata(s_wdata),
      .s_wstrb(s_wstrb),
      .s_rdata(s_rdata),
      .s_ready(s_ready),
      .grant  (grant),
      .busy   (busy)
   );

   assign s_rdata = mem[s_addr[6:2]];

   always @(posedge clk) begin
      if (s_valid && s_ready) begin
         for (int b = 0; b < 4; b++) begin
            if (s_wstrb[b])
               mem[s_addr[6:2]][b*8 +: 8] <= s_wdata[b*8 +: 8];
         end
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      logic [1:0] g2 [0:3];
      g2[0] = 2'b01;
      g2[1] = 2'b10;
      g2[2] = 2'b01;
      g2[3] = 2'b10;
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      mem[16] = 32'hCAFE_0040;
      mem[2]  = 32'h1122_3344;

      rst = 1'b0; boot = 1'b0; m_valid = 2'b00; s_ready = 1'b0;
      a0 = 32'h0; a1 = 32'h0; d0 = 32'h0; d1 = 32'h0;
      w0 = 4'h0; w1 = 4'h0;

      // reset state, including outputs forced while rst is low
      cyc(); #1;
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_svalid", 32'(s_valid), 32'h0);
      chk("rst_mready", 32'(m_ready), 32'h0);
      m_valid = 2'b11; #1;
      chk("rst_grant_req", 32'(grant), 32'h0);
      chk("rst_svalid_req", 32'(s_valid), 32'h0);
      m_valid = 2'b00;

      // single read by master 0, 1-cycle SRAM
      cyc(); rst = 1'b1;
      cyc(); m_valid = 2'b01; a0 = 32'h40; #1;
      chk("t1_svalid", 32'(s_valid), 32'h1);
      chk("t1_saddr", s_addr, 32'h40);
      chk("t1_grant", 32'(grant), 32'h1);
      chk("t1_busy0", 32'(busy), 32'h0);
      cyc(); s_ready = 1'b1; #1;
      chk("t1_busy1", 32'(busy), 32'h1);
      chk("t1_mready", 32'(m_ready), 32'h1);
      chk("t1_rdata", m_rdata, 32'hCAFE_0040);
      cyc(); s_ready = 1'b0; m_valid = 2'b00; #1;
      chk("t1_busy_end", 32'(busy), 32'h0);
      chk("t1_grant_idle", 32'(grant), 32'h0);
      chk("t1_svalid_idle", 32'(s_valid), 32'h0);

      // both masters requesting out of reset: 0,1,0,1
      rst = 1'b0; #1; rst = 1'b1;
      a0 = 32'h100; a1 = 32'h200;
      for (int i = 0; i < 4; i++) begin
         cyc(); m_valid = 2'b11; s_ready = 1'b0; #1;
         chk("t2_grant", 32'(grant), 32'(g2[i]));
         chk("t2_saddr", s_addr,
             (g2[i] == 2'b01) ? 32'h100 : 32'h200);
         chk("t2_mready_idle", 32'(m_ready), 32'h0);
         cyc(); s_ready = 1'b1; #1;
         chk("t2_mready", 32'(m_ready), 32'(g2[i]));
         chk("t2_busy", 32'(busy), 32'h1);
      end

      // boot priority: four grants to master 1, then master 0
      boot = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(); s_ready = 1'b0; #1;
         chk("t3_grant_boot", 32'(grant), 32'h2);
         cyc(); s_ready = 1'b1; #1;
         chk("t3_mready_boot", 32'(m_ready), 32'h2);
      end
      cyc(); boot = 1'b0; s_ready = 1'b0; #1;
      chk("t3_grant_after", 32'(grant), 32'h1);
      cyc(); s_ready = 1'b1; #1;
      chk("t3_mready_after", 32'(m_ready), 32'h1);
      cyc(); s_ready = 1'b0; m_valid = 2'b00; #1;
      chk("t3_busy_end", 32'(busy), 32'h0);

      // SRAM stall with master 0 arriving mid-transaction
      cyc(); m_valid = 2'b10; #1;
      chk("t4_grant", 32'(grant), 32'h2);
      cyc(); m_valid = 2'b11;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) cyc();
         #1;
         chk("t4_hold_addr", s_addr, 32'h200);
         chk("t4_hold_grant", 32'(grant), 32'h2);
         chk("t4_hold_mready", 32'(m_ready), 32'h0);
         chk("t4_hold_busy", 32'(busy), 32'h1);
      end
      cyc(); s_ready = 1'b1; #1;
      chk("t4_mready1", 32'(m_ready), 32'h2);
      cyc(); s_ready = 1'b0; m_valid = 2'b01; #1;
      chk("t4_grant0", 32'(grant), 32'h1);
      chk("t4_saddr0", s_addr, 32'h100);
      cyc(); s_ready = 1'b1; #1;
      chk("t4_mready0", 32'(m_ready), 32'h1);
      cyc(); s_ready = 1'b0; m_valid = 2'b00;

      // asynchronous reset during BUSY
      cyc(); m_valid = 2'b01; #1;
      chk("t5_grant", 32'(grant), 32'h1);
      cyc(); #1;
      chk("t5_busy", 32'(busy), 32'h1);
      s_ready = 1'b1; #1;
      chk("t5_mready_pre", 32'(m_ready), 32'h1);
      rst = 1'b0; #1;
      chk("t5_busy_rst", 32'(busy), 32'h0);
      chk("t5_svalid_rst", 32'(s_valid), 32'h0);
      chk("t5_mready_rst", 32'(m_ready), 32'h0);
      chk("t5_grant_rst", 32'(grant), 32'h0);
      cyc(); rst = 1'b1; m_valid = 2'b00; #1;
      chk("t5_stray_mready", 32'(m_ready), 32'h0);
      cyc(); s_ready = 1'b0; #1;
      chk("t5_stray_busy", 32'(busy), 32'h0);
      m_valid = 2'b11; #1;
      chk("t5_first_grant", 32'(grant), 32'h1);
      cyc(); s_ready = 1'b1; #1;
      chk("t5_first_mready", 32'(m_ready), 32'h1);
      cyc(); s_ready = 1'b0; m_valid = 2'b00;

      // partial write by master 1, then read back
      cyc();
      a1 = 32'h8; d1 = 32'hDEAD_BEEF; w1 = 4'b0011;
      m_valid = 2'b10; #1;
      chk("t6_grant", 32'(grant), 32'h2);
      chk("t6_saddr", s_addr, 32'h8);
      chk("t6_swdata", s_wdata, 32'hDEAD_BEEF);
      chk("t6_swstrb", 32'(s_wstrb), 32'h3);
      cyc(); s_ready = 1'b1; #1;
      chk("t6_mready_wr", 32'(m_ready), 32'h2);
      cyc(); s_ready = 1'b0; m_valid = 2'b00;
      cyc(); w1 = 4'b0000; m_valid = 2'b10; #1;
      chk("t6_swstrb_rd", 32'(s_wstrb), 32'h0);
      cyc(); s_ready = 1'b1; #1;
      chk("t6_mready_rd", 32'(m_ready), 32'h2);
      chk("t6_rdata", m_rdata, 32'h1122_BEEF);
      cyc(); s_ready = 1'b0; m_valid = 2'b00;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
